// File: rtl/bidir_step_counter.sv
// Bounded up/down counter with programmable step, saturate or wrap at the bounds,
// synchronous clamped load, and one-cycle sat/wrap event pulses.
module bidir_step_counter #(
  parameter int WIDTH       = 8,
  parameter int MIN_VALUE   = 0,
  parameter int MAX_VALUE   = 255,
  parameter int STEP_W      = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              upDown,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              sat_pulse,
  output logic              wrap_pulse
);

  localparam int EW = WIDTH + 1;
  localparam logic [EW-1:0]    MIN_E   = EW'(MIN_VALUE);
  localparam logic [EW-1:0]    MAX_E   = EW'(MAX_VALUE);
  localparam logic [EW-1:0]    RANGE_E = EW'(MAX_VALUE - MIN_VALUE + 1);
  localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             wrap_q, wrap_d;
  logic [EW-1:0]    cnt_e, step_e, sum_e;

  // One extra bit keeps count+step and MIN+step free of overflow.
  assign cnt_e  = {1'b0, count_q};
  assign step_e = EW'(step);
  assign sum_e  = cnt_e + step_e;

  always_comb begin
    count_d = count_q;
    sat_d   = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      if (load_value < MIN_C)      count_d = MIN_C;
      else if (load_value > MAX_C) count_d = MAX_C;
      else                         count_d = load_value;
    end else if (en && (step != '0)) begin
      if (upDown) begin
        if (sum_e <= MAX_E) begin
          count_d = WIDTH'(sum_e);
        end else if (wrap_mode) begin
          count_d = WIDTH'(sum_e - RANGE_E);
          wrap_d  = 1'b1;
        end else begin
          count_d = MAX_C;
          sat_d   = 1'b1;
        end
      end else begin
        // count-step >= MIN rewritten as count >= MIN+step to stay unsigned
        if (cnt_e >= MIN_E + step_e) begin
          count_d = WIDTH'(cnt_e - step_e);
        end else if (wrap_mode) begin
          count_d = WIDTH'(cnt_e + RANGE_E - step_e);
          wrap_d  = 1'b1;
        end else begin
          count_d = MIN_C;
          sat_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_C;
      sat_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign at_max     = (count_q == MAX_C);
  assign at_min     = (count_q == MIN_C);
  assign sat_pulse  = sat_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_bidir_step_counter.sv
// Self-checking bench: directed boundary cases plus randomized traffic against
// an integer model of the counter rules, checked every cycle.
module tb_bidir_step_counter;

  localparam int WIDTH  = 9;
  localparam int MINV   = 0;
  localparam int MAXV   = 255;
  localparam int STEP_W = 4;
  localparam int RSTV   = 0;

  logic              clk = 1'b0;
  logic              rst, en, upDown, wrap_mode, load;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  load_value;
  logic [WIDTH-1:0]  count;
  logic              at_max, at_min, sat_pulse, wrap_pulse;

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  int m_sat = 0;
  int m_wrap = 0;
  bit chk = 1'b0;

  always #5 clk = ~clk;

  bidir_step_counter #(
    .WIDTH(WIDTH), .MIN_VALUE(MINV), .MAX_VALUE(MAXV),
    .STEP_W(STEP_W), .RESET_VALUE(RSTV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .upDown(upDown), .step(step),
    .wrap_mode(wrap_mode), .load(load), .load_value(load_value),
    .count(count), .at_max(at_max), .at_min(at_min),
    .sat_pulse(sat_pulse), .wrap_pulse(wrap_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counter rules in plain signed integer arithmetic.
  task automatic model();
    int t;
    int range;
    range  = MAXV - MINV + 1;
    m_sat  = 0;
    m_wrap = 0;
    if (rst) begin
      m_cnt = RSTV;
    end else if (load) begin
      t = int'(load_value);
      m_cnt = (t < MINV) ? MINV : (t > MAXV) ? MAXV : t;
    end else if (en && step != 0) begin
      t = upDown ? m_cnt + int'(step) : m_cnt - int'(step);
      if (t > MAXV) begin
        if (wrap_mode) begin m_cnt = t - range; m_wrap = 1; end
        else           begin m_cnt = MAXV;      m_sat  = 1; end
      end else if (t < MINV) begin
        if (wrap_mode) begin m_cnt = t + range; m_wrap = 1; end
        else           begin m_cnt = MINV;      m_sat  = 1; end
      end else begin
        m_cnt = t;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #2;
    if (chk) begin
      check("count", 32'(count), m_cnt);
      check("at_max", 32'(at_max), int'(m_cnt == MAXV));
      check("at_min", 32'(at_min), int'(m_cnt == MINV));
      check("sat_pulse", 32'(sat_pulse), m_sat);
      check("wrap_pulse", 32'(wrap_pulse), m_wrap);
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = WIDTH'(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; upDown = 1'b1; wrap_mode = 1'b0; load = 1'b0;
    step = '0; load_value = '0;

    // reset
    tick(); tick();
    chk = 1'b1;
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_at_min", 32'(at_min), 1);
    check("rst_at_max", 32'(at_max), 0);
    check("rst_pulses", 32'({sat_pulse, wrap_pulse}), 0);

    // saturate up from 0 with step 1
    en = 1'b1; upDown = 1'b1; wrap_mode = 1'b0; step = 4'd1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (i == 255) begin
        check("sat_reach_255", 32'(count), 255);
        check("sat_land_nopulse", 32'(sat_pulse), 0);
      end
      if (i > 255) begin
        check("sat_hold_255", 32'(count), 255);
        check("sat_pulse_hold", 32'(sat_pulse), 1);
      end
    end

    // wrap up 250+7 -> 1
    do_load(250);
    check("load_250", 32'(count), 250);
    wrap_mode = 1'b1; step = 4'd7; en = 1'b1;
    tick();
    check("wrap_up_count", 32'(count), 1);
    check("wrap_up_pulse", 32'(wrap_pulse), 1);
    en = 1'b0;
    tick();
    check("wrap_pulse_clears", 32'(wrap_pulse), 0);

    // wrap down 1-3 -> 254, then saturate down 5-15 -> 0
    en = 1'b1; upDown = 1'b0; step = 4'd3;
    tick();
    check("wrap_dn_count", 32'(count), 254);
    check("wrap_dn_pulse", 32'(wrap_pulse), 1);
    do_load(5);
    wrap_mode = 1'b0; step = 4'd15;
    tick();
    check("sat_dn_count", 32'(count), 0);
    check("sat_dn_pulse", 32'(sat_pulse), 1);
    check("sat_dn_at_min", 32'(at_min), 1);

    // load clamps and overrides counting
    en = 1'b1; upDown = 1'b1; step = 4'd5;
    do_load(300);
    check("load_clamp", 32'(count), 255);
    check("load_nopulse", 32'({sat_pulse, wrap_pulse}), 0);
    do_load(17);
    check("load_17", 32'(count), 17);

    // rst beats load, then up to 200 and hold
    do_load(100);
    rst = 1'b1; load = 1'b1; load_value = 9'd50;
    tick();
    rst = 1'b0; load = 1'b0;
    check("rst_over_load", 32'(count), RSTV);
    do_load(195);
    en = 1'b1; upDown = 1'b1; step = 4'd5;
    tick();
    check("up_to_200", 32'(count), 200);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_200", 32'(count), 200);
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 11) == 0);
      en         = ($urandom_range(0, 3) != 0);
      upDown     = 1'($urandom_range(0, 1));
      wrap_mode  = 1'($urandom_range(0, 1));
      step       = STEP_W'($urandom);
      load_value = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(250, 511))
                                               : WIDTH'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
